// File: rtl/e_muldiv_unit.sv
// rtl/e_muldiv_unit.sv - execute-stage multiply/divide unit owning HI/LO
//
// Ports:
//   clk      in  1   rising-edge clock
//   reset_n  in  1   async active-low reset
//   start    in  1   one-cycle request, qualifies op/rs_d/rt_d
//   op       in  3   000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo
//   rs_d     in  32  operand A / mthi-mtlo source
//   rt_d     in  32  operand B
//   flush    in  1   abort in-flight op (only when MD_FLUSH_EN is defined)
//   busy     out 1   registered, high while a mult/div is running
//   hi, lo   out 32  HI/LO registers
//
// Optional feature macro: MD_FLUSH_EN (adds the flush port).
module e_muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_d,
    input  logic [31:0] rt_d,
`ifdef MD_FLUSH_EN
    input  logic        flush,
`endif
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [1:0]    op_q;   // bit1: divide, bit0: unsigned

    logic          flush_w;
`ifdef MD_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        div_zero;

    always_comb begin
        prod     = '0;
        quo      = '0;
        rem      = '0;
        div_zero = (b_q == 32'h0);
        if (op_q[0]) begin
            prod = {32'h0, a_q} * {32'h0, b_q};
            quo  = a_q / b_q;
            rem  = a_q % b_q;
        end else begin
            prod = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
            // Most-negative / -1 overflows a 32-bit signed quotient; pin the
            // wrapped result explicitly rather than relying on the simulator.
            if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
                quo = 32'h8000_0000;
                rem = 32'h0;
            end else begin
                quo = $signed(a_q) / $signed(b_q);
                rem = $signed(a_q) % $signed(b_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !flush_w) begin
                        case (op)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                a_q   <= rs_d;
                                b_q   <= rt_d;
                                op_q  <= op[1:0];
                                cnt   <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                                busy  <= 1'b1;
                                state <= S_RUN;
                            end
                            3'b100:  hi <= rs_d;
                            3'b101:  lo <= rs_d;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (flush_w) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (cnt == CW'(1)) begin
                        if (!op_q[1]) begin
                            hi <= prod[63:32];
                            lo <= prod[31:0];
                        end else if (!div_zero) begin
                            hi <= rem;
                            lo <= quo;
                        end
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_e_muldiv_unit.sv
// tb/tb_e_muldiv_unit.sv - self-checking bench for e_muldiv_unit
module tb_e_muldiv_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    e_muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .rs_d    (rs_d),
        .rt_d    (rt_d),
`ifdef MD_FLUSH_EN
        .flush   (flush),
`endif
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int cycles);
        longint          sp;
        longint unsigned up;
        longint          sq;
        longint          sr;
        cycles = 0;
        case (o)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                m_hi = sp[63:32]; m_lo = sp[31:0]; cycles = MC;
            end
            3'd1: begin
                up = {32'h0, a} * {32'h0, b};
                m_hi = up[63:32]; m_lo = up[31:0]; cycles = MC;
            end
            3'd2: begin
                cycles = DC;
                if (b != 0) begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    m_lo = sq[31:0]; m_hi = sr[31:0];
                end
            end
            3'd3: begin
                cycles = DC;
                if (b != 0) begin
                    m_lo = a / b; m_hi = a % b;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    // Called #1 after a rising edge. Issues one op, scrambles the operand
    // inputs afterwards, optionally keeps requesting junk ops while busy,
    // and checks busy length, hold-during-run and final HI/LO.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit junk);
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        int          exp_n;
        int          n;
        pre_hi = m_hi;
        pre_lo = m_lo;
        start = 1'b1; op = o; rs_d = a; rt_d = b;
        @(posedge clk); #1;
        start = 1'b0; rs_d = $urandom; rt_d = $urandom;
        model(o, a, b, exp_n);
        n = 0;
        while (busy && n < 40) begin
            chk({tag, " hold_hi"}, hi, pre_hi);
            chk({tag, " hold_lo"}, lo, pre_lo);
            if (junk) begin
                start = 1'b1;
                op    = ($urandom_range(0, 1) == 0) ? 3'd4 : 3'd0;
                rs_d  = $urandom;
                rt_d  = $urandom;
            end
            n++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({tag, " busy_cycles"}, n, exp_n);
        chk({tag, " hi"}, hi, m_hi);
        chk({tag, " lo"}, lo, m_lo);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        reset_n = 1'b1;
        start   = 1'b0;
        op      = 3'd0;
        rs_d    = 32'h0;
        rt_d    = 32'h0;
        flush   = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("reset busy", busy, 0);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        @(posedge clk); @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_op("mult", 3'd0, 32'd3, 32'hFFFF_FFFE, 0);
        chk("mult hi const", hi, 32'hFFFF_FFFF);
        chk("mult lo const", lo, 32'hFFFF_FFFA);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 0);
        chk("multu hi const", hi, 32'h1);
        chk("multu lo const", lo, 32'hFFFF_FFFE);
        run_op("div", 3'd2, 32'd7, 32'hFFFF_FFFE, 0);
        chk("div lo const", lo, 32'hFFFF_FFFD);
        chk("div hi const", hi, 32'h1);
        run_op("divu", 3'd3, 32'd7, 32'd2, 0);
        chk("divu lo const", lo, 32'd3);
        chk("divu hi const", hi, 32'd1);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("div_ovf lo const", lo, 32'h8000_0000);
        chk("div_ovf hi const", hi, 32'h0);

        run_op("mthi", 3'd4, 32'h11, 32'h0, 0);
        run_op("mtlo", 3'd5, 32'h22, 32'h0, 0);
        run_op("div0", 3'd2, 32'd5, 32'd0, 1);
        chk("div0 hi const", hi, 32'h11);
        chk("div0 lo const", lo, 32'h22);
        run_op("undef110", 3'd6, 32'h1234, 32'h5, 0);
        run_op("undef111", 3'd7, 32'h1234, 32'h5, 0);
        run_op("divu0", 3'd3, 32'd9, 32'd0, 0);

        // Asynchronous reset in the 3rd busy cycle of a mult.
        start = 1'b1; op = 3'd0; rs_d = 32'd9; rt_d = 32'd9;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        chk("pre_reset busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("async_reset busy", busy, 0);
        chk("async_reset hi", hi, 0);
        chk("async_reset lo", lo, 0);
        m_hi = 32'h0; m_lo = 32'h0;
        #7 reset_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_reset_mult", 3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);

`ifdef MD_FLUSH_EN
        run_op("pre_flush_mthi", 3'd4, 32'h5555, 32'h0, 0);
        start = 1'b1; op = 3'd2; rs_d = 32'd100; rt_d = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("flush pre busy", busy, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush busy", busy, 0);
        chk("flush hi", hi, m_hi);
        chk("flush lo", lo, m_lo);
        start = 1'b1; op = 3'd5; rs_d = 32'hABCD; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush mtlo lo", lo, m_lo);
        chk("flush mtlo busy", busy, 0);
`endif

        for (int i = 0; i < 30; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 3'($urandom_range(0, 7));
            ra = pick_operand();
            rb = pick_operand();
            run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
